muldiv_ctl: RTL and testbench
=============================

// Module: muldiv_ctl
// PURPOSE
//   Sequencer for the shared HI/LO multiply/divide resource of the 5-stage core.
//   Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the E stage. Runs each mult/div for a fixed cycle count, then commits HI/LO.
//   Raises a D-stage stall while any later HI/LO user would see stale or busy state.
//   Sits beside the E-stage ALU and feeds the hazard/stall logic alongside the forwarding control.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (legal 1..31)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (legal 1..31)
// PORTS
//   clk       in   1   clock, all state on rising edge
//   rst_n     in   1   asynchronous active-low reset
//   start_e   in   1   valid HI/LO-unit op in E stage this cycle
//   op_e      in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a_e       in   32  forwarded RS operand
//   b_e       in   32  forwarded RT operand
//   md_use_d  in   1   D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
//   cancel_i  in   1   exception/flush: kill in-flight and E-stage op
//   hi_o      out  32  architectural HI
//   lo_o      out  32  architectural LO
//   busy_o    out  1   mult/div in progress
//   stall_o   out  1   stall request to D stage
// BEHAVIOUR
//   Reset: hi_o=0, lo_o=0, busy_o=0, cnt=0, state IDLE; stall_o=0 (combinational, follows inputs).
//   FSM IDLE/BUSY.
//     IDLE: start_e & ~cancel_i & op 0..3 at edge k -> BUSY.
//       Result is computed from a_e/b_e and latched at edge k; cnt loaded with N-1.
//       N = MULT_CYCLES for op 0/1, DIV_CYCLES for op 2/3.
//     BUSY: cnt decrements each edge. At the edge where cnt==0: commit HI/LO, -> IDLE.
//     Timing: busy_o=1 for exactly N cycles (k+1..k+N). New hi_o/lo_o are visible from cycle k+N+1.
//   MTHI/MTLO (op 4/5) in IDLE, ~cancel_i: hi_o<=a_e or lo_o<=a_e at the next edge, no busy.
//   start_e while BUSY is ignored; the stall guarantees it cannot happen legally.
//   cancel_i: in BUSY -> IDLE at the next edge, HI/LO unchanged, pending result dropped.
//     Overrides a same-cycle start_e or a same-edge commit; cancel wins.
//   Arithmetic:
//     MULT: signed 32x32 -> 64, {HI,LO}. MULTU: unsigned 32x32 -> 64.
//     DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
//     DIVU: unsigned quotient/remainder.
//     Divide by zero (b=0): LO=32'hFFFF_FFFF, HI=a.
//     DIV overflow (a=32'h8000_0000, b=32'hFFFF_FFFF): LO=32'h8000_0000, HI=0.
//   stall_o = md_use_d & (busy_o | (start_e & ~cancel_i & op_e<=3)).
//     D stage is held until the cycle after commit. No stall for MTHI/MTLO in E.
//   Reset asserted mid-operation: immediate return to reset values, no commit.
// TESTING
//   1. MULT a=-3 b=7 -> busy_o 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
//   2. DIV a=-7 b=2 -> busy_o 10 cycles; then LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
//      DIVU a=7 b=0 -> LO=32'hFFFF_FFFF, HI=7.
//   3. MULTU a=32'hFFFF_FFFF b=2 followed by mflo in D (md_use_d=1).
//      -> stall_o=1 from the issue cycle through the last busy cycle;
//      -> stall_o=0 in cycle k+N+1 with LO=32'hFFFF_FFFE, HI=1.
//   4. MTHI a=32'h1234 in IDLE -> hi_o=32'h1234 next cycle, busy_o never 1, stall_o=0.
//   5. DIV started, cancel_i pulsed in busy cycle 3 -> busy_o=0 next cycle, HI/LO keep prior values.
//      cancel_i on the final busy cycle -> no commit.
//   6. rst_n low for one cycle mid-MULT -> all outputs 0 asynchronously; no later commit after release.

Source files
------------

// File: rtl/muldiv_ctl.sv
// rtl/muldiv_ctl.sv - HI/LO multiply/divide sequencer with D-stage stall generation
// Result is computed combinationally at issue and held until the fixed busy window expires.
module muldiv_ctl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_e,
    input  logic [2:0]  op_e,
    input  logic [31:0] a_e,
    input  logic [31:0] b_e,
    input  logic        md_use_d,
    input  logic        cancel_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        stall_o
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    logic        md_op;
    logic        is_mult;
    logic        launch;
    logic        write_hi;
    logic        write_lo;
    logic        commit;

    logic        signed_op;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] mul_res;

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign md_op    = (op_e <= OP_DIVU);
    assign is_mult  = (op_e == OP_MULT) || (op_e == OP_MULTU);
    assign launch   = (state == IDLE) && start_e && !cancel_i && md_op;
    assign write_hi = (state == IDLE) && start_e && !cancel_i && (op_e == OP_MTHI);
    assign write_lo = (state == IDLE) && start_e && !cancel_i && (op_e == OP_MTLO);
    assign commit   = (state == BUSY) && (cnt == 5'd0) && !cancel_i;

    // One 64x64 multiplier serves both forms: sign- or zero-extension picks the flavour.
    assign signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign ext_a     = {{32{signed_op & a_e[31]}}, a_e};
    assign ext_b     = {{32{signed_op & b_e[31]}}, b_e};
    assign mul_res   = ext_a * ext_b;

    // Divide on magnitudes, then restore signs: quotient toward zero, remainder follows dividend.
    always_comb begin
        neg_a   = signed_op && a_e[31];
        neg_b   = signed_op && b_e[31];
        mag_a   = neg_a ? (32'd0 - a_e) : a_e;
        mag_b   = neg_b ? (32'd0 - b_e) : b_e;
        divisor = (b_e == 32'd0) ? 32'd1 : mag_b;
        uquot   = mag_a / divisor;
        urem    = mag_a % divisor;
        div_q   = (neg_a ^ neg_b) ? (32'd0 - uquot) : uquot;
        div_r   = neg_a ? (32'd0 - urem) : urem;
        if (b_e == 32'd0) begin
            div_q = 32'hFFFF_FFFF;
            div_r = a_e;
        end else if ((op_e == OP_DIV) && (a_e == 32'h8000_0000) && (b_e == 32'hFFFF_FFFF)) begin
            div_q = 32'h8000_0000;
            div_r = 32'd0;
        end
    end

    always_comb begin
        if (is_mult) begin
            res_hi = mul_res[63:32];
            res_lo = mul_res[31:0];
        end else begin
            res_hi = div_r;
            res_lo = div_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = BUSY;
            BUSY: if (cancel_i || (cnt == 5'd0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state == BUSY);
        stall_o = md_use_d && (busy_o || (start_e && !cancel_i && md_op));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 5'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else if (launch) begin
            cnt     <= is_mult ? MULT_LOAD : DIV_LOAD;
            pend_hi <= res_hi;
            pend_lo <= res_lo;
        end else if ((state == BUSY) && (cnt != 5'd0)) begin
            cnt <= cnt - 5'd1;
        end else if (state == BUSY) begin
            cnt <= 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (commit) begin
            hi_q <= pend_hi;
            lo_q <= pend_lo;
        end else begin
            if (write_hi) hi_q <= a_e;
            if (write_lo) lo_q <= a_e;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctl.sv
// tb/tb_muldiv_ctl.sv - scoreboard bench for muldiv_ctl
module tb_muldiv_ctl;

    logic        clk;
    logic        rst_n;
    logic        start_e;
    logic [2:0]  op_e;
    logic [31:0] a_e;
    logic [31:0] b_e;
    logic        md_use_d;
    logic        cancel_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic        stall_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp;
    int          n_fail;
    int          run_len;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_ctl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_e  (start_e),
        .op_e     (op_e),
        .a_e      (a_e),
        .b_e      (b_e),
        .md_use_d (md_use_d),
        .cancel_i (cancel_i),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .busy_o   (busy_o),
        .stall_o  (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every busy window that closes is matched against the next scoreboard entry.
    initial begin
        run_len = 0;
        forever begin
            @(negedge clk);
            if (busy_o === 1'b1) begin
                run_len++;
            end else if (run_len > 0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected: busy window of %0d cycles with no expected entry", run_len);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("busy_cycles", 32'(run_len), 32'(e.cyc));
                    check("hi", hi_o, e.hi);
                    check("lo", lo_o, e.lo);
                end
                run_len = 0;
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int n;
        n = (op <= 3'd1) ? 5 : 10;
        sb.push_back('{eh, el, n});
        @(posedge clk); #1;
        start_e = 1'b1; op_e = op; a_e = a; b_e = b;
        @(posedge clk); #1;
        start_e = 1'b0;
        repeat (n + 1) @(posedge clk);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        rst_n = 1'b0; start_e = 1'b0; op_e = 3'd7; a_e = 32'd0; b_e = 32'd0;
        md_use_d = 1'b0; cancel_i = 1'b0;
        #2;
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(3'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        run_op(3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run_op(3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3);
        run_op(3'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);

        // MULTU with a dependent mflo waiting in D
        sb.push_back('{32'd1, 32'hFFFF_FFFE, 5});
        @(posedge clk); #1;
        start_e = 1'b1; op_e = 3'd1; a_e = 32'hFFFF_FFFF; b_e = 32'd2; md_use_d = 1'b1;
        @(negedge clk);
        check("stall_issue", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        start_e = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_busy", {31'd0, stall_o}, 32'd1);
        end
        @(negedge clk);
        check("stall_release", {31'd0, stall_o}, 32'd0);
        check("stall_lo", lo_o, 32'hFFFF_FFFE);
        md_use_d = 1'b0;
        m_hi = 32'd1; m_lo = 32'hFFFF_FFFE;

        // MTHI / MTLO
        @(posedge clk); #1;
        start_e = 1'b1; op_e = 3'd4; a_e = 32'h1234; md_use_d = 1'b1;
        @(negedge clk);
        check("mthi_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        op_e = 3'd5; a_e = 32'h5678;
        @(negedge clk);
        check("mthi_hi", hi_o, 32'h1234);
        check("mthi_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        start_e = 1'b0; md_use_d = 1'b0;
        @(negedge clk);
        check("mtlo_lo", lo_o, 32'h5678);
        check("mtlo_hi", hi_o, 32'h1234);
        m_hi = 32'h1234; m_lo = 32'h5678;

        // cancel in the same cycle as issue: nothing starts
        @(posedge clk); #1;
        start_e = 1'b1; op_e = 3'd0; a_e = 32'd9; b_e = 32'd9; cancel_i = 1'b1; md_use_d = 1'b1;
        @(negedge clk);
        check("cancel_issue_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        start_e = 1'b0; cancel_i = 1'b0; md_use_d = 1'b0;
        @(negedge clk);
        check("cancel_issue_busy", {31'd0, busy_o}, 32'd0);

        // cancel in busy cycle 3
        sb.push_back('{m_hi, m_lo, 3});
        @(posedge clk); #1;
        start_e = 1'b1; op_e = 3'd2; a_e = 32'd100; b_e = 32'd7;
        @(posedge clk); #1;
        start_e = 1'b0;
        repeat (2) @(posedge clk);
        #1 cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("cancel3_hi_late", hi_o, m_hi);
        check("cancel3_lo_late", lo_o, m_lo);

        // cancel on the final busy cycle
        sb.push_back('{m_hi, m_lo, 10});
        @(posedge clk); #1;
        start_e = 1'b1; op_e = 3'd2; a_e = 32'd100; b_e = 32'd7;
        @(posedge clk); #1;
        start_e = 1'b0;
        repeat (9) @(posedge clk);
        #1 cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        repeat (3) @(posedge clk);

        // asynchronous reset in the middle of a MULT
        sb.push_back('{32'd0, 32'd0, 2});
        @(posedge clk); #1;
        start_e = 1'b1; op_e = 3'd0; a_e = 32'd3; b_e = 32'd3;
        @(posedge clk); #1;
        start_e = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("amid_rst_hi", hi_o, 32'd0);
        check("amid_rst_lo", lo_o, 32'd0);
        check("amid_rst_busy", {31'd0, busy_o}, 32'd0);
        #9 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_hi", hi_o, 32'd0);
        check("post_rst_lo", lo_o, 32'd0);
        check("post_rst_busy", {31'd0, busy_o}, 32'd0);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
